// File: rtl/h264_stream_pkg.sv
// Shared types and geometry for the H.264 MM2S stream path.
package h264_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int PIX_W       = 8;
  localparam int MB_DIM      = 16;
  localparam int FIFO_WORD_W = 8 * PIX_W;
  localparam int ROW_W       = MB_DIM * PIX_W;
  localparam int ROW_IDX_W   = 4;

endpackage

// File: rtl/h264_mm2s_mb_row_unpacker.sv
// Pairs 64-bit FIFO words into 128-bit macroblock rows and tags them with raster MB position.
// state | meaning
// IDLE  | waiting for start with non-zero cfg
// RUN   | popping word pairs and forming rows
// DRAIN | final row loaded, waiting for encoder to take it
module h264_mm2s_mb_row_unpacker
  import h264_stream_pkg::*;
#(
  parameter int MB_COLS_W = 8,
  parameter int MB_ROWS_W = 8
) (
  input  logic                   H264_ACLK,
  input  logic                   H264_ARESETN,
  input  logic                   start_i,
  input  logic [MB_COLS_W-1:0]   cfg_mb_cols_i,
  input  logic [MB_ROWS_W-1:0]   cfg_mb_rows_i,
  output logic                   busy_o,
  output logic                   frame_done_o,
  input  logic                   H264_RVALID_I,
  input  logic [FIFO_WORD_W-1:0] H264_RDATA_I,
  output logic                   H264_RREADY_O,
  output logic                   row_valid_o,
  input  logic                   row_ready_i,
  output logic [ROW_W-1:0]       row_data_o,
  output logic [ROW_IDX_W-1:0]   row_idx_o,
  output logic [MB_COLS_W-1:0]   mb_x_o,
  output logic [MB_ROWS_W-1:0]   mb_y_o,
  output logic                   mb_first_o,
  output logic                   mb_last_o,
  output logic                   frame_last_o
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_phase;
  logic [FIFO_WORD_W-1:0] r_lo;
  logic [MB_COLS_W-1:0]   r_cols;
  logic [MB_ROWS_W-1:0]   r_rows;
  logic [ROW_IDX_W-1:0]   r_cnt_row;
  logic [MB_COLS_W-1:0]   r_cnt_x;
  logic [MB_ROWS_W-1:0]   r_cnt_y;
  logic                   r_row_valid;
  logic [ROW_W-1:0]       r_row_data;
  logic [ROW_IDX_W-1:0]   r_row_idx;
  logic [MB_COLS_W-1:0]   r_mb_x;
  logic [MB_ROWS_W-1:0]   r_mb_y;
  logic                   r_frame_last;
  logic                   r_frame_done;

  logic w_start_ok;
  logic w_rready;
  logic w_pop;
  logic w_lo_acc;
  logic w_hi_acc;
  logic w_row_hs;
  logic w_row_wrap;
  logic w_col_wrap;
  logic w_last_in;

  assign w_start_ok = start_i && (cfg_mb_cols_i != '0) && (cfg_mb_rows_i != '0);
  assign w_pop      = H264_RVALID_I && w_rready;
  assign w_lo_acc   = w_pop && !r_phase;
  assign w_hi_acc   = w_pop && r_phase;
  assign w_row_hs   = r_row_valid && row_ready_i;
  assign w_row_wrap = (r_cnt_row == ROW_IDX_W'(MB_DIM - 1));
  assign w_col_wrap = (r_cnt_x == r_cols - MB_COLS_W'(1));
  assign w_last_in  = w_row_wrap && w_col_wrap && (r_cnt_y == r_rows - MB_ROWS_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_rready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // a lo word can always be taken; a hi word needs the output slot free or draining
        w_rready = !r_phase || !r_row_valid || row_ready_i;
        if (H264_RVALID_I && w_rready && r_phase && w_last_in) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_row_hs) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge H264_ACLK) begin
    if (!H264_ARESETN) begin
      r_state      <= ST_IDLE;
      r_phase      <= 1'b0;
      r_lo         <= '0;
      r_cols       <= '0;
      r_rows       <= '0;
      r_cnt_row    <= '0;
      r_cnt_x      <= '0;
      r_cnt_y      <= '0;
      r_row_valid  <= 1'b0;
      r_row_data   <= '0;
      r_row_idx    <= '0;
      r_mb_x       <= '0;
      r_mb_y       <= '0;
      r_frame_last <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= (r_state == ST_DRAIN) && w_row_hs;

      if ((r_state == ST_IDLE) && w_start_ok) begin
        r_cols    <= cfg_mb_cols_i;
        r_rows    <= cfg_mb_rows_i;
        r_cnt_row <= '0;
        r_cnt_x   <= '0;
        r_cnt_y   <= '0;
        r_phase   <= 1'b0;
      end

      if (w_lo_acc) begin
        r_lo    <= H264_RDATA_I;
        r_phase <= 1'b1;
      end

      if (w_hi_acc) begin
        r_phase <= 1'b0;
        if (w_row_wrap) begin
          r_cnt_row <= '0;
          if (w_col_wrap) begin
            r_cnt_x <= '0;
            r_cnt_y <= r_cnt_y + MB_ROWS_W'(1);
          end else begin
            r_cnt_x <= r_cnt_x + MB_COLS_W'(1);
          end
        end else begin
          r_cnt_row <= r_cnt_row + ROW_IDX_W'(1);
        end
      end

      // reload in the same cycle as a drain keeps the 1-row-per-2-cycles rate
      if (w_hi_acc) begin
        r_row_valid  <= 1'b1;
        r_row_data   <= {H264_RDATA_I, r_lo};
        r_row_idx    <= r_cnt_row;
        r_mb_x       <= r_cnt_x;
        r_mb_y       <= r_cnt_y;
        r_frame_last <= w_last_in;
      end else if (w_row_hs) begin
        r_row_valid <= 1'b0;
      end
    end
  end

  assign busy_o        = (r_state != ST_IDLE);
  assign frame_done_o  = r_frame_done;
  assign H264_RREADY_O = w_rready;
  assign row_valid_o   = r_row_valid;
  assign row_data_o    = r_row_data;
  assign row_idx_o     = r_row_idx;
  assign mb_x_o        = r_mb_x;
  assign mb_y_o        = r_mb_y;
  assign mb_first_o    = (r_row_idx == '0);
  assign mb_last_o     = (r_row_idx == ROW_IDX_W'(MB_DIM - 1));
  assign frame_last_o  = r_frame_last;

endmodule

// File: tb/tb_h264_mm2s_mb_row_unpacker.sv
// Scoreboard bench for the MB row unpacker: raster tags, pairing, stalls, cfg/start/reset corners.
module tb_h264_mm2s_mb_row_unpacker;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic [7:0]   cfg_mb_cols_i;
  logic [7:0]   cfg_mb_rows_i;
  logic         busy_o;
  logic         frame_done_o;
  logic         H264_RVALID_I;
  logic [63:0]  H264_RDATA_I;
  logic         H264_RREADY_O;
  logic         row_valid_o;
  logic         row_ready_i;
  logic [127:0] row_data_o;
  logic [3:0]   row_idx_o;
  logic [7:0]   mb_x_o;
  logic [7:0]   mb_y_o;
  logic         mb_first_o;
  logic         mb_last_o;
  logic         frame_last_o;

  always #5 clk = ~clk;

  h264_mm2s_mb_row_unpacker #(.MB_COLS_W(8), .MB_ROWS_W(8)) dut (
    .H264_ACLK     (clk),
    .H264_ARESETN  (rst_n),
    .start_i       (start_i),
    .cfg_mb_cols_i (cfg_mb_cols_i),
    .cfg_mb_rows_i (cfg_mb_rows_i),
    .busy_o        (busy_o),
    .frame_done_o  (frame_done_o),
    .H264_RVALID_I (H264_RVALID_I),
    .H264_RDATA_I  (H264_RDATA_I),
    .H264_RREADY_O (H264_RREADY_O),
    .row_valid_o   (row_valid_o),
    .row_ready_i   (row_ready_i),
    .row_data_o    (row_data_o),
    .row_idx_o     (row_idx_o),
    .mb_x_o        (mb_x_o),
    .mb_y_o        (mb_y_o),
    .mb_first_o    (mb_first_o),
    .mb_last_o     (mb_last_o),
    .frame_last_o  (frame_last_o)
  );

  typedef struct packed {
    logic [127:0] d;
    logic [3:0]   idx;
    logic [7:0]   x;
    logic [7:0]   y;
    logic         fl;
  } exp_t;

  int n_checks = 0;
  int n_err    = 0;

  logic [63:0] wq[$];
  exp_t        exp_q[$];

  int m_row, m_x, m_y, m_cols, m_rows;
  logic        m_phase;
  logic [63:0] m_lo;

  int gap_pct, stall_pct;
  bit poke;
  int cyc, frame_cyc, done_cnt, done_cyc, last_hs_cyc, rows_out;
  logic busy_at_done;
  logic [127:0] first_data;
  logic held_valid;
  logic [148:0] held;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [63:0] w;
    exp_t e;
    @(negedge clk);
    H264_RVALID_I = (wq.size() > 0) && ($urandom_range(99) >= gap_pct);
    H264_RDATA_I  = (wq.size() > 0) ? wq[0] : 64'h0;
    row_ready_i   = ($urandom_range(99) >= stall_pct);
    if (poke && frame_cyc == 20) begin
      start_i       = 1'b1;
      cfg_mb_cols_i = 8'd7;
      cfg_mb_rows_i = 8'd9;
    end else begin
      start_i = 1'b0;
    end
    #4;
    cyc++;
    frame_cyc++;
    if (held_valid) begin
      check("hold_valid", row_valid_o, 1'b1);
      check("hold_row", {row_data_o, row_idx_o, mb_x_o, mb_y_o, frame_last_o}, held);
    end
    if (m_phase && row_valid_o && !row_ready_i) check("rready_full", H264_RREADY_O, 1'b0);
    if (frame_done_o) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = busy_o;
    end
    if (H264_RVALID_I && H264_RREADY_O) begin
      w = wq.pop_front();
      if (!m_phase) begin
        m_lo    = w;
        m_phase = 1'b1;
      end else begin
        e.d   = {w, m_lo};
        e.idx = m_row[3:0];
        e.x   = m_x[7:0];
        e.y   = m_y[7:0];
        e.fl  = (m_row == 15) && (m_x == m_cols - 1) && (m_y == m_rows - 1);
        exp_q.push_back(e);
        m_phase = 1'b0;
        if (m_row == 15) begin
          m_row = 0;
          if (m_x == m_cols - 1) begin m_x = 0; m_y++; end
          else m_x++;
        end else m_row++;
      end
    end
    if (row_valid_o && row_ready_i) begin
      check("sb_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (rows_out == 0) first_data = row_data_o;
        check("row_data", row_data_o, e.d);
        check("row_idx", row_idx_o, e.idx);
        check("mb_x", mb_x_o, e.x);
        check("mb_y", mb_y_o, e.y);
        check("mb_first", mb_first_o, e.idx == 4'd0);
        check("mb_last", mb_last_o, e.idx == 4'd15);
        check("frame_last", frame_last_o, e.fl);
      end
      rows_out++;
      last_hs_cyc = cyc;
    end
    held_valid = row_valid_o && !row_ready_i;
    held       = {row_data_o, row_idx_o, mb_x_o, mb_y_o, frame_last_o};
  endtask

  task automatic start_frame(input int cols, input int rows, input logic exp_busy);
    @(negedge clk);
    H264_RVALID_I = 1'b0;
    row_ready_i   = 1'b1;
    cfg_mb_cols_i = cols[7:0];
    cfg_mb_rows_i = rows[7:0];
    start_i       = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    #4;
    check("busy_after_start", busy_o, exp_busy);
    if (exp_busy) begin
      m_cols = cols; m_rows = rows;
      m_row = 0; m_x = 0; m_y = 0; m_phase = 1'b0;
    end
  endtask

  task automatic run_frame(input int cols, input int rows, input bit ramp,
                           input int gap, input int stall, input bit do_poke);
    int total;
    logic [63:0] w;
    total = cols * rows * 16;
    start_frame(cols, rows, 1'b1);
    for (int k = 0; k < total * 2; k++) begin
      if (ramp) for (int b = 0; b < 8; b++) w[8*b +: 8] = 8'((8 * k + b) & 255);
      else      w = {$urandom, $urandom};
      wq.push_back(w);
    end
    gap_pct = gap; stall_pct = stall; poke = do_poke;
    done_cnt = 0; rows_out = 0; frame_cyc = 0; held_valid = 1'b0; busy_at_done = 1'b1;
    while (!(rows_out == total && done_cnt > 0) && frame_cyc < 5000) step();
    poke = 1'b0;
    repeat (3) step();
    check("rows_out", rows_out, total);
    check("frame_done_cnt", done_cnt, 1);
    check("done_latency", done_cyc - last_hs_cyc, 1);
    check("busy_at_done", busy_at_done, 1'b0);
    check("busy_idle", busy_o, 1'b0);
    if (ramp) check("row0_px", first_data, 128'h0f0e0d0c0b0a09080706050403020100);
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; cfg_mb_cols_i = 8'd0; cfg_mb_rows_i = 8'd0;
    H264_RVALID_I = 1'b0; H264_RDATA_I = 64'h0; row_ready_i = 1'b0;
    cyc = 0; poke = 1'b0; gap_pct = 0; stall_pct = 0; m_phase = 1'b0;
    repeat (3) @(negedge clk);
    #4;
    check("rst_busy", busy_o, 1'b0);
    check("rst_rready", H264_RREADY_O, 1'b0);
    check("rst_row_valid", row_valid_o, 1'b0);
    check("rst_row_data", row_data_o, 128'h0);
    check("rst_done", frame_done_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // single MB, back-to-back, ramp pixels
    run_frame(1, 1, 1'b1, 0, 0, 1'b0);

    // 2x2 MBs with input gaps and encoder stalls
    run_frame(2, 2, 1'b0, 30, 40, 1'b0);

    // zero-size cfg must not start
    start_frame(0, 3, 1'b0);
    repeat (3) step();
    check("cfg0_busy", busy_o, 1'b0);
    check("cfg0_rready", H264_RREADY_O, 1'b0);
    start_frame(2, 0, 1'b0);
    repeat (2) step();
    check("rows0_busy", busy_o, 1'b0);

    // start pulse and cfg change mid-frame are ignored
    run_frame(3, 1, 1'b0, 10, 20, 1'b1);
    cfg_mb_cols_i = 8'd0;

    // reset after a lo word mid-frame
    start_frame(1, 1, 1'b1);
    wq.push_back(64'hdead_beef_0123_4567);
    gap_pct = 0; stall_pct = 0; frame_cyc = 0; done_cnt = 0;
    while (wq.size() != 0 && frame_cyc < 20) step();
    check("lo_accepted", wq.size(), 0);
    @(negedge clk);
    rst_n = 1'b0; H264_RVALID_I = 1'b0;
    @(negedge clk);
    #1;
    check("mrst_busy", busy_o, 1'b0);
    check("mrst_rready", H264_RREADY_O, 1'b0);
    check("mrst_row_valid", row_valid_o, 1'b0);
    check("mrst_row_data", row_data_o, 128'h0);
    check("mrst_done", frame_done_o, 1'b0);
    rst_n = 1'b1;
    m_phase = 1'b0;
    exp_q.delete();
    run_frame(1, 1, 1'b1, 20, 20, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
